ahb_apb_xfer_ctrl: RTL and testbench

Sequencing controller for the AHB-to-APB bridge. Accepts single AHB transfers, decodes each address to one of three APB slaves, and runs the APB SETUP/ACCESS sequence. Stalls the AHB data phase via Hreadyout and returns read data or an ERROR response. Sits between the AHB master-side signals and the APB slave-side signals of the bridge's driver/monitor interface.

---
 rtl/ahb_apb_xfer_ctrl.sv | 116 +++++++++++
 tb/tb_ahb_apb_xfer_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_xfer_ctrl.sv
// AHB-to-APB bridge sequencer: decodes single AHB transfers onto three APB slaves,
// runs SETUP/ACCESS, stalls the AHB data phase and returns read data or ERROR.
module ahb_apb_xfer_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_BITS = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hreadyout,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  state_t      state;
  logic [1:0]  sel;
  logic [32:0] diff;
  logic [31:0] idx;
  logic        borrow, hit, req;

  // Bit 32 of the widened subtraction is the borrow, flagging addresses below the window.
  assign diff   = {1'b0, Haddr} - {1'b0, BASE_ADDR};
  assign borrow = diff[32];
  assign idx    = diff[31:0] >> REGION_BITS;
  assign hit    = !borrow && (idx < 32'd3);
  assign req    = Hreadyin && Htrans[1];

  function automatic logic [2:0] onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  // Outputs are registered alongside the state so each one reflects the state it enters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 2'd0;
      Hrdata    <= 32'd0;
      Hresp     <= RESP_OKAY;
      Hreadyout <= 1'b1;
      Pselx     <= 3'b000;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= 32'd0;
      Pwdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            Paddr     <= Haddr;
            Pwrite    <= Hwrite;
            sel       <= idx[1:0];
            Hreadyout <= 1'b0;
            if (Hwrite) begin
              state <= WDATA;
            end else begin
              state <= SETUP;
              Pselx <= onehot(idx[1:0]);
            end
          end else if (req) begin
            state     <= ERR1;
            Hresp     <= RESP_ERR;
            Hreadyout <= 1'b0;
          end
        end
        WDATA: begin
          Pwdata <= Hwdata;
          Pselx  <= onehot(sel);
          state  <= SETUP;
        end
        SETUP: begin
          Penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (!Pwrite) Hrdata <= Prdata;
          Pselx     <= 3'b000;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
          state     <= IDLE;
        end
        ERR1: begin
          Hreadyout <= 1'b1;
          state     <= ERR2;
        end
        ERR2: begin
          // Master cancels after ERROR; anything presented now is dropped.
          Hresp <= RESP_OKAY;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          Hresp     <= RESP_OKAY;
          Hreadyout <= 1'b1;
          Pselx     <= 3'b000;
          Penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_xfer_ctrl.sv
// Directed bench for ahb_apb_xfer_ctrl; cycle Tn starts 1 time unit after posedge n.
module tb_ahb_apb_xfer_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic [31:0] Hrdata, Paddr, Pwdata;
  logic [1:0]  Hresp;
  logic        Hreadyout, Penable, Pwrite;
  logic [2:0]  Pselx;

  int total = 0;
  int bad   = 0;

  ahb_apb_xfer_ctrl dut (
    .clk(clk), .reset(reset), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hrdata(Hrdata), .Hresp(Hresp),
    .Hreadyout(Hreadyout), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Common status check: select, enable, ready, response.
  task automatic st(input string tag, input logic [2:0] sx, input logic en,
                    input logic rdy, input logic [1:0] rsp);
    chk({tag, ".psel"}, 32'(Pselx), 32'(sx));
    chk({tag, ".pen"},  32'(Penable), 32'(en));
    chk({tag, ".rdy"},  32'(Hreadyout), 32'(rdy));
    chk({tag, ".resp"}, 32'(Hresp), 32'(rsp));
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [1:0] t, input logic rin);
    Haddr = a; Hwrite = w; Htrans = t; Hreadyin = rin;
  endtask

  task automatic idle_bus();
    Htrans = 2'b00; Hreadyin = 1'b1;
  endtask

  initial begin
    reset = 1'b1; Hwrite = 0; Hreadyin = 1; Htrans = 0; Haddr = 0; Hwdata = 0; Prdata = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    // reset state
    st("rst", 3'b000, 0, 1, 2'b00);
    chk("rst.hrdata", Hrdata, 32'h0);
    chk("rst.paddr",  Paddr,  32'h0);
    chk("rst.pwdata", Pwdata, 32'h0);
    chk("rst.pwrite", 32'(Pwrite), 32'h0);

    // write to slave 1
    req(32'h8400_0010, 1, 2'b10, 1);
    cyc();                                   // T1 WDATA
    idle_bus(); Hwdata = 32'hDEAD_BEEF;
    st("wr.T1", 3'b000, 0, 0, 2'b00);
    cyc();                                   // T2 SETUP
    Hwdata = 32'h0;
    st("wr.T2", 3'b010, 0, 0, 2'b00);
    chk("wr.paddr",  Paddr,  32'h8400_0010);
    chk("wr.pwdata", Pwdata, 32'hDEAD_BEEF);
    cyc();                                   // T3 ACCESS
    st("wr.T3", 3'b010, 1, 0, 2'b00);
    chk("wr.pwrite", 32'(Pwrite), 32'h1);
    cyc();                                   // T4
    st("wr.T4", 3'b000, 0, 1, 2'b00);
    chk("wr.hrdata_hold", Hrdata, 32'h0);

    // read from slave 2
    req(32'h8800_0004, 0, 2'b10, 1);
    cyc();                                   // T1
    idle_bus();
    st("rd.T1", 3'b100, 0, 0, 2'b00);
    chk("rd.pwrite", 32'(Pwrite), 32'h0);
    chk("rd.paddr",  Paddr, 32'h8800_0004);
    cyc();                                   // T2
    Prdata = 32'h1234_5678;
    st("rd.T2", 3'b100, 1, 0, 2'b00);
    chk("rd.T2.hrdata_old", Hrdata, 32'h0);
    cyc();                                   // T3
    Prdata = 32'h0;
    st("rd.T3", 3'b000, 0, 1, 2'b00);
    chk("rd.hrdata", Hrdata, 32'h1234_5678);
    chk("rd.pwdata_hold", Pwdata, 32'hDEAD_BEEF);

    // out-of-range: above window, then below base
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a;
      a = (k == 0) ? 32'h8C00_0000 : 32'h7FFF_FFFC;
      req(a, 0, 2'b10, 1);
      cyc();                                 // T1 ERR1
      idle_bus();
      st($sformatf("miss%0d.T1", k), 3'b000, 0, 0, 2'b01);
      cyc();                                 // T2 ERR2; offer a hit that must be dropped
      req(32'h8000_0000, 0, 2'b10, 1);
      st($sformatf("miss%0d.T2", k), 3'b000, 0, 1, 2'b01);
      cyc();                                 // T3
      idle_bus();
      st($sformatf("miss%0d.T3", k), 3'b000, 0, 1, 2'b00);
      chk($sformatf("miss%0d.paddr", k), Paddr, 32'h8800_0004);
      cyc();
      st($sformatf("miss%0d.T4", k), 3'b000, 0, 1, 2'b00);
    end

    // back-to-back read then write
    req(32'h8000_0000, 0, 2'b10, 1);
    cyc();                                   // T1
    idle_bus();
    st("b2b.T1", 3'b001, 0, 0, 2'b00);
    cyc();                                   // T2
    Prdata = 32'hCAFE_0001;
    cyc();                                   // T3: completes read, present write
    Prdata = 32'h0;
    st("b2b.T3", 3'b000, 0, 1, 2'b00);
    chk("b2b.hrdata", Hrdata, 32'hCAFE_0001);
    req(32'h8400_0000, 1, 2'b11, 1);
    cyc();                                   // T4 WDATA
    idle_bus(); Hwdata = 32'h0000_55AA;
    st("b2b.T4", 3'b000, 0, 0, 2'b00);
    cyc();                                   // T5 SETUP
    st("b2b.T5", 3'b010, 0, 0, 2'b00);
    chk("b2b.pwdata", Pwdata, 32'h0000_55AA);
    chk("b2b.paddr",  Paddr,  32'h8400_0000);
    cyc();                                   // T6 ACCESS
    st("b2b.T6", 3'b010, 1, 0, 2'b00);
    cyc();
    st("b2b.T7", 3'b000, 0, 1, 2'b00);
    chk("b2b.hrdata_hold", Hrdata, 32'hCAFE_0001);

    // BUSY and Hreadyin low start nothing
    req(32'h8000_0100, 0, 2'b01, 1);
    cyc();
    st("busy.T1", 3'b000, 0, 1, 2'b00);
    req(32'h8000_0100, 0, 2'b10, 0);
    cyc();
    st("nrdy.T1", 3'b000, 0, 1, 2'b00);
    idle_bus();
    cyc();
    st("nrdy.T2", 3'b000, 0, 1, 2'b00);
    chk("nrdy.paddr", Paddr, 32'h8400_0000);

    // reset mid-ACCESS
    req(32'h8000_0020, 0, 2'b10, 1);
    cyc();
    idle_bus();
    cyc();                                   // ACCESS
    Prdata = 32'hBAD0_BAD0;
    st("prerst", 3'b001, 1, 0, 2'b00);
    reset = 1'b1;
    #1;
    st("arst", 3'b000, 0, 1, 2'b00);
    chk("arst.hrdata", Hrdata, 32'h0);
    chk("arst.paddr",  Paddr,  32'h0);
    #2 reset = 1'b0;
    Prdata = 32'h0;
    cyc();
    st("postrst.T1", 3'b000, 0, 1, 2'b00);
    chk("postrst.hrdata", Hrdata, 32'h0);
    cyc();
    st("postrst.T2", 3'b000, 0, 1, 2'b00);

    // operation resumes after reset
    req(32'h8000_0008, 0, 2'b10, 1);
    cyc();
    idle_bus();
    st("resume.T1", 3'b001, 0, 0, 2'b00);
    cyc();
    Prdata = 32'h0BAD_F00D;
    cyc();
    st("resume.T3", 3'b000, 0, 1, 2'b00);
    chk("resume.hrdata", Hrdata, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
